led_scan_mux: RTL

LED_SCAN_MUX -- requirements
Module: led_scan_mux

---
 rtl/led_scan_mux_pkg.sv | 12 +
 rtl/switch_debounce.sv | 49 ++++
 rtl/led_scan_mux.sv | 124 ++++++++++++
 3 files changed

// File: rtl/led_scan_mux_pkg.sv
// Shared types and constants for the LED scan multiplexer.
// Holds the mode FSM encoding and the fallback LED pattern.
package led_scan_mux_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    localparam logic [63:0] DEFAULT_PATTERN_ALL = '1;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer.
// The output moves only after a full run of identical samples.
module switch_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] last;
    logic [CW-1:0]    run;
    logic [CW-1:0]    run_next;

    // run counts consecutive equal samples, saturating at the target
    always_comb begin
        run_next = run;
        if (sync2 != last) begin
            run_next = CW'(1);
        end else if (run != CW'(DEBOUNCE_CYCLES)) begin
            run_next = run + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            last   <= '0;
            run    <= '0;
            stable <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            last  <= sync2;
            run   <= run_next;
            if (sync2 != stable && run_next == CW'(DEBOUNCE_CYCLES)) begin
                stable <= sync2;
            end
        end
    end

endmodule

// File: rtl/led_scan_mux.sv
// LED channel multiplexer with debounced manual select and auto-scan.
// Scan advances to the next valid channel after each dwell period.
module led_scan_mux
    import led_scan_mux_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = 8,
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [DATA_W-1:0] DEFAULT_PATTERN =
        DATA_W'(DEFAULT_PATTERN_ALL),
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel_sw,
    input  logic                     mode_sw,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [DATA_W-1:0]        led,
    output logic [SEL_W-1:0]         active_ch,
    output logic                     scan_tick
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [SEL_W-1:0]  sel_db;
    logic              mode_db;
    state_t            state;
    state_t            state_next;
    logic [DW-1:0]     dwell;
    logic [DW-1:0]     dwell_next;
    logic [SEL_W-1:0]  ch_next;
    logic [SEL_W-1:0]  ch_search;
    logic              tick_next;
    logic              force_default;
    logic              sel_ok;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic [DATA_W-1:0] led_next;

    switch_debounce #(
        .WIDTH           (SEL_W + 1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    ({mode_sw, sel_sw}),
        .stable ({mode_db, sel_db})
    );

    assign sel_ok = ({1'b0, sel_db} < (SEL_W + 1)'(NUM_CH));

    // first valid channel above active_ch, wrapping; hold if none
    always_comb begin
        logic found;
        int   idx;
        ch_search = active_ch;
        found     = 1'b0;
        for (int i = 1; i < NUM_CH; i++) begin
            idx = (int'(active_ch) + i) % NUM_CH;
            if (!found && ch_valid[idx]) begin
                ch_search = SEL_W'(idx);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = mode_db ? SCAN : MANUAL;
        ch_next       = active_ch;
        dwell_next    = '0;
        tick_next     = 1'b0;
        force_default = 1'b0;
        unique case (1'b1)
            (state_next == MANUAL): begin
                if (sel_ok) ch_next = sel_db;
                else force_default = 1'b1;
            end
            (state == MANUAL && state_next == SCAN): begin
                dwell_next = '0;
            end
            (state == SCAN && state_next == SCAN): begin
                if (dwell == DW'(DWELL_CYCLES - 1)) begin
                    tick_next = 1'b1;
                    ch_next   = ch_search;
                end else begin
                    dwell_next = dwell + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_data  = DEFAULT_PATTERN;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_next == SEL_W'(k)) begin
                sel_data  = ch_data[k*DATA_W +: DATA_W];
                sel_valid = ch_valid[k];
            end
        end
        led_next = (force_default || !sel_valid) ? DEFAULT_PATTERN
                                                 : sel_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MANUAL;
            dwell     <= '0;
            active_ch <= '0;
            led       <= '0;
            scan_tick <= 1'b0;
        end else begin
            state     <= state_next;
            dwell     <= dwell_next;
            active_ch <= ch_next;
            led       <= led_next;
            scan_tick <= tick_next;
        end
    end

endmodule
